spi_ram_arbiter: RTL and testbench

Shares one single-port synchronous RAM between two SPI-slave command streams.
- Each requester sends the 10-bit rx_data command format: bits[9:8] are the opcode, bits[7:0] are the payload.
- The block keeps per-port write and read address latches and arbitrates RAM accesses round-robin.
- Read data returns to the issuing port with a valid/ack handshake, so the SPI slave can shift tx_data out over 8 cycles.
- It sits between the SPI slave instances and the RAM macro.

---
 rtl/spi_ram_arb_pkg.sv | 24 ++
 rtl/spi_ram_port_ctx.sv | 54 +++++
 rtl/spi_ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arb_pkg.sv
// rtl/spi_ram_arb_pkg.sv - shared types for the two-port SPI command RAM arbiter
package spi_ram_arb_pkg;

    localparam int CMD_W = 10;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT
    } arb_state_e;

    // RAM opcodes are the ones that need the arbiter; address opcodes only touch latches
    function automatic logic is_ram_op(input opcode_e op);
        return (op == WR_DATA) || (op == RD_DATA);
    endfunction

endpackage

// File: rtl/spi_ram_port_ctx.sv
// rtl/spi_ram_port_ctx.sv - per-port address latches, read-pending flag and read response register
module spi_ram_port_ctx
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_accept,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic              rdata_load,
    input  logic [DATA_W-1:0] rdata,
    input  logic              tx_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pending,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data
);

    opcode_e op;

    assign op = opcode_e'(cmd_data[CMD_W-1 -: 2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
        end else begin
            if (cmd_accept && op == WR_ADDR)
                wr_addr <= cmd_data[ADDR_W-1:0];
            if (cmd_accept && op == RD_ADDR)
                rd_addr <= cmd_data[ADDR_W-1:0];

            // an ack with nothing to consume must not release the pending read
            if (cmd_accept && op == RD_DATA)
                rd_pending <= 1'b1;
            else if (tx_valid && tx_ack)
                rd_pending <= 1'b0;

            if (rdata_load) begin
                tx_valid <= 1'b1;
                tx_data  <= rdata;
            end else if (tx_ack) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - round-robin RAM arbiter for two SPI command ports; SPI_ARB_FIXED_PRIO_EN selects fixed port0 priority
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [CMD_W-1:0]  req0_data,
    output logic              req0_ready,
    output logic              req0_tx_valid,
    output logic [DATA_W-1:0] req0_tx_data,
    input  logic              req0_tx_ack,
    input  logic              req1_valid,
    input  logic [CMD_W-1:0]  req1_data,
    output logic              req1_ready,
    output logic              req1_tx_valid,
    output logic [DATA_W-1:0] req1_tx_data,
    input  logic              req1_tx_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    arb_state_e        state, state_nxt;
    opcode_e           op0, op1, acc_op;
    logic              pend0, pend1;
    logic              ram_req0, ram_req1, gnt0, gnt1;
    logic              ram_acc0, ram_acc1;
    logic              issue_we, owner, rd_load, lat_done;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] wa0, ra0, wa1, ra1, acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign op0 = opcode_e'(req0_data[CMD_W-1 -: 2]);
    assign op1 = opcode_e'(req1_data[CMD_W-1 -: 2]);

    assign ram_req0 = req0_valid && !pend0 && is_ram_op(op0);
    assign ram_req1 = req1_valid && !pend1 && is_ram_op(op1);

`ifdef SPI_ARB_FIXED_PRIO_EN
    assign gnt0 = ram_req0;
    assign gnt1 = ram_req1 && !ram_req0;
`else
    // last_p1 starts set so port0 wins the first conflict after reset
    logic last_p1;

    assign gnt0 = ram_req0 && (!ram_req1 || last_p1);
    assign gnt1 = ram_req1 && (!ram_req0 || !last_p1);

    always_ff @(posedge clk) begin
        if (rst)
            last_p1 <= 1'b1;
        else if (ram_acc0)
            last_p1 <= 1'b0;
        else if (ram_acc1)
            last_p1 <= 1'b1;
    end
`endif

    assign req0_ready = !rst && req0_valid && !pend0 &&
                        (is_ram_op(op0) ? (state == IDLE && gnt0) : 1'b1);
    assign req1_ready = !rst && req1_valid && !pend1 &&
                        (is_ram_op(op1) ? (state == IDLE && gnt1) : 1'b1);

    assign ram_acc0 = req0_ready && is_ram_op(op0);
    assign ram_acc1 = req1_ready && is_ram_op(op1);

    assign acc_op    = ram_acc1 ? op1 : op0;
    assign acc_wdata = ram_acc1 ? req1_data[DATA_W-1:0] : req0_data[DATA_W-1:0];
    assign acc_addr  = ram_acc1 ? ((op1 == WR_DATA) ? wa1 : ra1)
                                : ((op0 == WR_DATA) ? wa0 : ra0);

    // ram_addr/ram_wdata keep their last value between accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= 1'b0;
            issue_we  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (ram_acc0 || ram_acc1) begin
            owner    <= ram_acc1;
            issue_we <= (acc_op == WR_DATA);
            ram_addr <= acc_addr;
            if (acc_op == WR_DATA)
                ram_wdata <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != RD_WAIT)
            lat_cnt <= '0;
        else
            lat_cnt <= lat_cnt + 2'd1;
    end

    assign lat_done = (lat_cnt == 2'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ram_acc0 || ram_acc1) state_nxt = ISSUE;
            ISSUE:   state_nxt = issue_we ? IDLE : RD_WAIT;
            RD_WAIT: if (lat_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        rd_load = 1'b0;
        case (state)
            ISSUE: begin
                ram_en = 1'b1;
                ram_we = issue_we;
            end
            RD_WAIT: rd_load = lat_done;
            default: ;
        endcase
    end

    spi_ram_port_ctx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ctx0 (
        .clk        (clk),
        .rst        (rst),
        .cmd_accept (req0_ready),
        .cmd_data   (req0_data),
        .rdata_load (rd_load && !owner),
        .rdata      (ram_rdata),
        .tx_ack     (req0_tx_ack),
        .wr_addr    (wa0),
        .rd_addr    (ra0),
        .rd_pending (pend0),
        .tx_valid   (req0_tx_valid),
        .tx_data    (req0_tx_data)
    );

    spi_ram_port_ctx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ctx1 (
        .clk        (clk),
        .rst        (rst),
        .cmd_accept (req1_ready),
        .cmd_data   (req1_data),
        .rdata_load (rd_load && owner),
        .rdata      (ram_rdata),
        .tx_ack     (req1_tx_ack),
        .wr_addr    (wa1),
        .rd_addr    (ra1),
        .rd_pending (pend1),
        .tx_valid   (req1_tx_valid),
        .tx_data    (req1_tx_data)
    );

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - scoreboard bench: dut_a default build, dut_b with RD_LAT=3 and ADDR_W=4
module tb_spi_ram_arbiter;
    import spi_ram_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] valid_v, ack_v, ready_v, txv_v;
    logic [9:0] data_v [4];
    logic [7:0] txd_v [4];
    logic [1:0] en_v, we_v;
    logic [7:0] addr_a, wdata_a, rdata_a, wdata_b, rdata_b;
    logic [3:0] addr_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct { int d; logic we; logic [7:0] addr; logic [7:0] data; } ram_exp_t;
    typedef struct { int ch; logic [7:0] data; int cyc; } tx_exp_t;
    ram_exp_t ram_q[$];
    tx_exp_t  tx_q[$];
    logic [7:0] exp_wa [4];
    logic [7:0] exp_ra [4];

    spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(valid_v[0]), .req0_data(data_v[0]), .req0_ready(ready_v[0]),
        .req0_tx_valid(txv_v[0]), .req0_tx_data(txd_v[0]), .req0_tx_ack(ack_v[0]),
        .req1_valid(valid_v[1]), .req1_data(data_v[1]), .req1_ready(ready_v[1]),
        .req1_tx_valid(txv_v[1]), .req1_tx_data(txd_v[1]), .req1_tx_ack(ack_v[1]),
        .ram_en(en_v[0]), .ram_we(we_v[0]), .ram_addr(addr_a),
        .ram_wdata(wdata_a), .ram_rdata(rdata_a)
    );

    spi_ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(valid_v[2]), .req0_data(data_v[2]), .req0_ready(ready_v[2]),
        .req0_tx_valid(txv_v[2]), .req0_tx_data(txd_v[2]), .req0_tx_ack(ack_v[2]),
        .req1_valid(valid_v[3]), .req1_data(data_v[3]), .req1_ready(ready_v[3]),
        .req1_tx_valid(txv_v[3]), .req1_tx_data(txd_v[3]), .req1_tx_ack(ack_v[3]),
        .ram_en(en_v[1]), .ram_we(we_v[1]), .ram_addr(addr_b),
        .ram_wdata(wdata_b), .ram_rdata(rdata_b)
    );

    // RAM macro models: latency 1 for dut_a, 3-stage output pipe for dut_b
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [16];
    logic [7:0] pipe_b [3];

    always @(posedge clk) begin
        if (en_v[0] && we_v[0]) mem_a[addr_a] <= wdata_a;
        if (en_v[0] && !we_v[0]) rdata_a <= mem_a[addr_a];
        if (en_v[1] && we_v[1]) mem_b[addr_b] <= wdata_b;
        pipe_b[0] <= mem_b[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat(input int ch);
        return (ch >= 2) ? 3 : 1;
    endfunction

    function automatic logic [7:0] amask(input int ch);
        return (ch >= 2) ? 8'h0F : 8'hFF;
    endfunction

    task automatic push_ram(input int d, input logic we, input logic [7:0] a, input logic [7:0] dt);
        ram_exp_t e;
        e.d = d; e.we = we; e.addr = a; e.data = dt;
        ram_q.push_back(e);
    endtask

    // Drive one command and hold it until accepted; t returns the accept cycle
    task automatic send(input int ch, input logic [1:0] op, input logic [7:0] pl, output int t);
        int n;
        n = 0;
        data_v[ch]  = {op, pl};
        valid_v[ch] = 1'b1;
        @(negedge clk);
        while (!ready_v[ch] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("cmd_accept_ch%0d", ch), ready_v[ch], 1'b1);
        t = cyc;
        if (op == WR_ADDR) exp_wa[ch] = pl & amask(ch);
        if (op == RD_ADDR) exp_ra[ch] = pl & amask(ch);
        @(posedge clk);
        #1;
        valid_v[ch] = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [7:0] dt);
        int t;
        push_ram(ch / 2, 1'b1, exp_wa[ch], dt);
        send(ch, WR_DATA, dt, t);
    endtask

    task automatic rd(input int ch, input logic [7:0] exp_d);
        int t;
        tx_exp_t e;
        push_ram(ch / 2, 1'b0, exp_ra[ch], 8'h00);
        send(ch, RD_DATA, 8'h00, t);
        e.ch = ch; e.data = exp_d; e.cyc = t + 2 + lat(ch);
        tx_q.push_back(e);
    endtask

    task automatic wait_tx(input int ch);
        int n;
        n = 0;
        while (!txv_v[ch] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("tx_arrive_ch%0d", ch), txv_v[ch], 1'b1);
    endtask

    task automatic ack(input int ch);
        @(posedge clk);
        #1 ack_v[ch] = 1'b1;
        @(posedge clk);
        #1 ack_v[ch] = 1'b0;
    endtask

    // Monitor: pops expectations on each RAM strobe and each new read response
    logic [3:0] pv, pa;
    logic [7:0] pd [4];
    int ridx, tidx;

    always @(negedge clk) begin
        if (rst) begin
            pv = '0;
            pa = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (en_v[d]) begin
                    ridx = -1;
                    foreach (ram_q[i]) if (ridx < 0 && ram_q[i].d == d) ridx = i;
                    if (ridx < 0) begin
                        tests++; fails++;
                        $display("FAIL ram_unexpected_dut%0d: got ram_en=1, expected 0", d);
                    end else begin
                        check($sformatf("ram_we_dut%0d", d), we_v[d], ram_q[ridx].we);
                        check($sformatf("ram_addr_dut%0d", d),
                              (d == 1) ? {4'h0, addr_b} : addr_a, ram_q[ridx].addr);
                        if (ram_q[ridx].we)
                            check($sformatf("ram_wdata_dut%0d", d),
                                  (d == 1) ? wdata_b : wdata_a, ram_q[ridx].data);
                        ram_q.delete(ridx);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (txv_v[c] && !pv[c]) begin
                    tidx = -1;
                    foreach (tx_q[i]) if (tidx < 0 && tx_q[i].ch == c) tidx = i;
                    if (tidx < 0) begin
                        tests++; fails++;
                        $display("FAIL tx_unexpected_ch%0d: got tx_valid=1, expected 0", c);
                    end else begin
                        check($sformatf("tx_data_ch%0d", c), txd_v[c], tx_q[tidx].data);
                        check($sformatf("tx_cycle_ch%0d", c), cyc, tx_q[tidx].cyc);
                        tx_q.delete(tidx);
                    end
                end else if (pv[c] && pa[c]) begin
                    check($sformatf("tx_drop_ch%0d", c), txv_v[c], 1'b0);
                end else if (pv[c]) begin
                    check($sformatf("tx_hold_ch%0d", c), txv_v[c], 1'b1);
                    check($sformatf("tx_data_hold_ch%0d", c), txd_v[c], pd[c]);
                end
                pd[c] = txd_v[c];
            end
            pv = txv_v;
            pa = ack_v;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        ram_q.delete();
        tx_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_wa[i] = 8'h00;
            exp_ra[i] = 8'h00;
        end
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, t0, t1;
        rst     = 1'b1;
        valid_v = '0;
        ack_v   = '0;
        for (int i = 0; i < 4; i++) data_v[i] = '0;
        @(posedge clk);
        do_reset(3);

        // reset state
        @(negedge clk);
        check("rst_ready", ready_v, 4'h0);
        check("rst_tx_valid", txv_v, 4'h0);
        check("rst_ram_en", en_v, 2'b00);
        check("rst_ram_we", we_v, 2'b00);
        check("rst_ram_addr_a", addr_a, 8'h00);
        check("rst_ram_wdata_a", wdata_a, 8'h00);
        check("rst_tx_data0", txd_v[0], 8'h00);
        @(posedge clk); #1;

        // write then read back on port0, response held 8 cycles before ack
        send(0, WR_ADDR, 8'h12, t);
        wr(0, 8'hAB);
        send(0, RD_ADDR, 8'h12, t);
        rd(0, 8'hAB);
        wait_tx(0);
        repeat (8) @(posedge clk);
        ack(0);

        // port0 read pending blocks its address command; port1 proceeds
        rd(0, 8'hAB);
        data_v[0]  = {WR_ADDR, 8'h05};
        valid_v[0] = 1'b1;
        send(1, WR_ADDR, 8'h40, t);
        wr(1, 8'h77);
        @(negedge clk);
        check("pend_blocks_ready0", ready_v[0], 1'b0);
        wait_tx(0);
        check("pend_blocks_ready0_tx", ready_v[0], 1'b0);
        ack(0);
        @(negedge clk);
        check("ready0_after_ack", ready_v[0], 1'b1);
        exp_wa[0] = 8'h05;
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        wr(0, 8'h99);

        // ack with no response outstanding, then a normal read on port1
        ack(1);
        @(negedge clk);
        check("stray_ack_tx1", txv_v[1], 1'b0);
        @(posedge clk); #1;
        send(1, RD_ADDR, 8'h40, t);
        rd(1, 8'h77);
        wait_tx(1);
        ack(1);

        // simultaneous WR_DATA conflicts straight after reset
        do_reset(2);
        fork
            send(0, WR_ADDR, 8'h20, t0);
            send(1, WR_ADDR, 8'h30, t1);
        join
        check("addr_ops_same_cycle", t0, t1);
`ifdef SPI_ARB_FIXED_PRIO_EN
        push_ram(0, 1'b1, 8'h20, 8'hA0);
        push_ram(0, 1'b1, 8'h20, 8'hA1);
        push_ram(0, 1'b1, 8'h30, 8'hB0);
        push_ram(0, 1'b1, 8'h30, 8'hB1);
`else
        push_ram(0, 1'b1, 8'h20, 8'hA0);
        push_ram(0, 1'b1, 8'h30, 8'hB0);
        push_ram(0, 1'b1, 8'h20, 8'hA1);
        push_ram(0, 1'b1, 8'h30, 8'hB1);
`endif
        fork
            begin
                send(0, WR_DATA, 8'hA0, t0);
                send(0, WR_DATA, 8'hA1, t0);
            end
            begin
                send(1, WR_DATA, 8'hB0, t1);
                send(1, WR_DATA, 8'hB1, t1);
            end
        join

        // reset during RD_WAIT drops the read and clears the latches
        send(0, WR_ADDR, 8'h33, t);
        send(0, RD_ADDR, 8'h21, t);
        push_ram(0, 1'b0, 8'h21, 8'h00);
        send(0, RD_DATA, 8'h00, t);
        @(posedge clk); #1;
        do_reset(1);
        @(negedge clk);
        check("mid_rst_ready", ready_v[1:0], 2'b00);
        check("mid_rst_tx_valid", txv_v[1:0], 2'b00);
        check("mid_rst_ram_en", en_v[0], 1'b0);
        check("mid_rst_ram_we", we_v[0], 1'b0);
        check("mid_rst_ram_addr", addr_a, 8'h00);
        check("mid_rst_ram_wdata", wdata_a, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        wr(0, 8'h5A);
        rd(0, 8'h5A);
        wait_tx(0);
        ack(0);

        // narrow address and longer read latency build
        send(2, WR_ADDR, 8'hF7, t);
        wr(2, 8'hC3);
        send(2, RD_ADDR, 8'h07, t);
        rd(2, 8'hC3);
        wait_tx(2);
        ack(2);

        repeat (6) @(posedge clk);
        check("ram_queue_empty", ram_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
